// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl : interrupt aggregator feeding the core's MTIP / MSIP / MEIP inputs.
//
// Purpose
//   Collects the timer interrupt, a software-interrupt register bit and up to
//   NUM_SRC-1 peripheral lines. Each peripheral line passes through a level or
//   edge gateway into a pending bit. Pending bits are masked by ENABLE and
//   OR-reduced into irq_external_o. Software uses a claim/complete handshake
//   over a simple one-cycle bus:
//     0x00 PENDING (RO)   0x04 ENABLE (RW)   0x08 EDGE_SEL (RW, 1=edge)
//     0x0C CLAIM (read = claim, write = complete)   0x10 MSIP (RW, bit0)
//   Source ID 0 is reserved, so bit 0 of every per-source register reads 0.
//   Bits at or above NUM_SRC also read 0.
//
// Configuration
//   NUM_SRC           number of source lines including reserved ID 0 (2..32)
//   IRQ_CTRL_SYNC_EN  when defined, each irq_src_i bit passes through a 2-flop
//                     synchroniser before the gateway. This adds two cycles of
//                     edge-to-irq_external_o latency. timer_intr_i is never
//                     synchronised.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   irq_req_i, irq_we_i     bus request strobe (one cycle per access), write flag
//   irq_sel_i               byte select (ignored; every write is a full word)
//   irq_addr_i, irq_wdata_i byte address (only [9:0] decoded), write data
//   irq_rvalid_o            high exactly one cycle after a read request
//   irq_rdata_o             registered read data
//   timer_intr_i            level interrupt from mtime/mtimecmp
//   irq_src_i               peripheral interrupt lines (bit 0 ignored)
//   irq_timer_o             registered copy of timer_intr_i (MTIP)
//   irq_software_o          MSIP register bit (MSIP)
//   irq_external_o          registered OR of pending & enable (MEIP)
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NUM_SRC = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               irq_req_i,
    input  logic [3:0]         irq_sel_i,
    input  logic [31:0]        irq_addr_i,
    input  logic               irq_we_i,
    input  logic [31:0]        irq_wdata_i,
    output logic               irq_rvalid_o,
    output logic [31:0]        irq_rdata_o,
    input  logic               timer_intr_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic               irq_timer_o,
    output logic               irq_software_o,
    output logic               irq_external_o
);

    // Usable source bits: 1..NUM_SRC-1.
    localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFE
                                     : (((32'd1 << NUM_SRC) - 32'd1) & 32'hFFFF_FFFE);

    localparam logic [9:0] ADDR_PENDING  = 10'h000;
    localparam logic [9:0] ADDR_ENABLE   = 10'h004;
    localparam logic [9:0] ADDR_EDGE_SEL = 10'h008;
    localparam logic [9:0] ADDR_CLAIM    = 10'h00C;
    localparam logic [9:0] ADDR_MSIP     = 10'h010;

    logic [31:0] pending;
    logic [31:0] enable;
    logic [31:0] edge_sel;
    logic [31:0] in_service;
    logic [31:0] src_prev;
    logic        msip;

    logic [31:0] src_raw;
    logic [31:0] src;
    logic [9:0]  addr;
    logic        is_rd;
    logic        is_wr;
    logic        is_claim;
    logic        is_complete;
    logic [31:0] active;
    logic [4:0]  claim_id;
    logic [31:0] claim_onehot;
    logic [4:0]  complete_id;
    logic [31:0] complete_onehot;
    logic [31:0] gw_set;
    logic [31:0] rd_word;

    // Byte select and the upper address bits carry no meaning here.
    logic unused;
    assign unused = ^{irq_sel_i, irq_addr_i[31:10]};

    assign src_raw = 32'(irq_src_i) & SRC_MASK;

`ifdef IRQ_CTRL_SYNC_EN
    logic [31:0] sync_q1;
    logic [31:0] sync_q2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = src_raw;
`endif

    assign addr        = irq_addr_i[9:0];
    assign is_rd       = irq_req_i & ~irq_we_i;
    assign is_wr       = irq_req_i &  irq_we_i;
    assign is_claim    = is_rd & (addr == ADDR_CLAIM);
    assign is_complete = is_wr & (addr == ADDR_CLAIM);

    // Claim arbitration uses the registered ENABLE, so an ENABLE write in the
    // same cycle only affects later claims.
    assign active = pending & enable;

    always_comb begin
        claim_id = 5'd0;
        for (int i = 31; i >= 1; i--) begin
            if (active[i]) begin
                claim_id = 5'(i);
            end
        end
    end

    assign claim_onehot = (is_claim && (claim_id != 5'd0)) ? (32'd1 << claim_id) : 32'd0;

    // Out-of-range and ID-0 completes fall outside SRC_MASK and vanish.
    assign complete_id     = irq_wdata_i[4:0];
    assign complete_onehot = is_complete ? ((32'd1 << complete_id) & SRC_MASK) : 32'd0;

    // Gateway set terms. A level source being claimed this cycle must not
    // re-set its own pending bit. An edge that coincides with a claim does
    // re-set it, because a fresh edge is a new request.
    always_comb begin
        gw_set = ((edge_sel  & src & ~src_prev)
               |  (~edge_sel & src & ~in_service & ~claim_onehot)) & SRC_MASK;
    end

    always_comb begin
        rd_word = 32'd0;
        case (addr)
            ADDR_PENDING:  rd_word = pending  & SRC_MASK;
            ADDR_ENABLE:   rd_word = enable   & SRC_MASK;
            ADDR_EDGE_SEL: rd_word = edge_sel & SRC_MASK;
            ADDR_CLAIM:    rd_word = {27'd0, claim_id};
            ADDR_MSIP:     rd_word = {31'd0, msip};
            default:       rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending        <= '0;
            enable         <= '0;
            edge_sel       <= '0;
            in_service     <= '0;
            src_prev       <= '0;
            msip           <= 1'b0;
            irq_rvalid_o   <= 1'b0;
            irq_rdata_o    <= '0;
            irq_timer_o    <= 1'b0;
            irq_external_o <= 1'b0;
        end else begin
            src_prev       <= src;
            pending        <= ((pending & ~claim_onehot) | gw_set) & SRC_MASK;
            in_service     <= ((in_service & ~complete_onehot) | claim_onehot) & SRC_MASK;
            irq_timer_o    <= timer_intr_i;
            irq_external_o <= |active;
            irq_rvalid_o   <= is_rd;
            if (is_rd) begin
                irq_rdata_o <= rd_word;
            end
            if (is_wr && (addr == ADDR_ENABLE)) begin
                enable <= irq_wdata_i & SRC_MASK;
            end
            if (is_wr && (addr == ADDR_EDGE_SEL)) begin
                edge_sel <= irq_wdata_i & SRC_MASK;
            end
            if (is_wr && (addr == ADDR_MSIP)) begin
                msip <= irq_wdata_i[0];
            end
        end
    end

    assign irq_software_o = msip;

endmodule
